// File: rtl/mas_seq_pkg.sv
// Shared types and widths for the MAS operand sequencer and its result FIFO.
package mas_seq_pkg;

  localparam int D_W = 5;
  localparam int R_W = 4;
  localparam int T_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    HALF,
    ISSUE
  } state_e;

  typedef struct packed {
    logic [R_W-1:0] dout;
    logic [T_W-1:0] tcmp;
  } res_t;

endpackage

// File: rtl/mas_operand_sequencer_if.sv
// Sample stream, MAS operand/result bus and result stream of the operand sequencer.
// master = sequencer side, slave = surrounding environment (source, MAS, consumer).
interface mas_operand_sequencer_if
  import mas_seq_pkg::*;
#(
  parameter int DEPTH = 4
);

  logic                   in_valid;
  logic                   in_ready;
  logic [D_W-1:0]         in_data;

  logic [D_W-1:0]         mas_din1;
  logic [D_W-1:0]         mas_din2;
  logic [1:0]             mas_sel;
  logic [D_W-1:0]         mas_q;
  logic [T_W-1:0]         mas_tcmp;
  logic [R_W-1:0]         mas_dout;

  logic                   out_valid;
  logic                   out_ready;
  logic [R_W-1:0]         out_dout;
  logic [T_W-1:0]         out_tcmp;
  logic [$clog2(DEPTH):0] out_count;

  modport master (
    input  in_valid, in_data, mas_tcmp, mas_dout, out_ready,
    output in_ready, mas_din1, mas_din2, mas_sel, mas_q,
           out_valid, out_dout, out_tcmp, out_count
  );

  modport slave (
    output in_valid, in_data, mas_tcmp, mas_dout, out_ready,
    input  in_ready, mas_din1, mas_din2, mas_sel, mas_q,
           out_valid, out_dout, out_tcmp, out_count
  );

endinterface

// File: rtl/mas_res_fifo.sv
// Circular result FIFO; full/empty are judged on the registered count, so a push
// into a full FIFO waits a cycle even when a pop happens in the same cycle.
module mas_res_fifo
  import mas_seq_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = res_t,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        push_i,
  input  T            push_data_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o,
  output T            head_o
);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem[rd_ptr_q];

  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o && !clr_i;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data_i;
    end
  end

  // Power-of-two depth lets the pointers wrap on their own width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mas_operand_sequencer.sv
// Pairs incoming samples into MAS operands and buffers MAS results in a FIFO.
// Optional build macro MAS_SEQ_STATS_EN adds per-Tcmp saturating push counters.
module mas_operand_sequencer
  import mas_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_sel,
  input  logic [D_W-1:0]       cfg_q,
`ifdef MAS_SEQ_STATS_EN
  output logic [4*8-1:0]       stat_cnt,
`endif
  mas_operand_sequencer_if.master bus
);

  state_e         state_q, state_d;
  logic [D_W-1:0] din1_q, din1_d;
  logic [D_W-1:0] din2_q, din2_d;
  logic [1:0]     sel_q, sel_d;
  logic [D_W-1:0] qv_q, qv_d;
  logic [1:0]     cfg_sel_q;
  logic [D_W-1:0] cfg_qv_q;
  logic           accept;
  logic           push;
  logic           full;
  logic           empty;
  res_t           push_data;
  res_t           head;

  assign bus.in_ready = !clr && (state_q != ISSUE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign push_data    = '{dout: bus.mas_dout, tcmp: bus.mas_tcmp};

  assign bus.mas_din1 = din1_q;
  assign bus.mas_din2 = din2_q;
  assign bus.mas_sel  = sel_q;
  assign bus.mas_q    = qv_q;

  always_comb begin
    state_d = state_q;
    din1_d  = din1_q;
    din2_d  = din2_q;
    sel_d   = sel_q;
    qv_d    = qv_q;
    push    = 1'b0;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          din1_d  = bus.in_data;
          state_d = HALF;
        end
        // Config is read from the registers, so a same-cycle cfg_we is not yet visible.
        HALF: if (accept) begin
          din2_d  = bus.in_data;
          sel_d   = cfg_sel_q;
          qv_d    = cfg_qv_q;
          state_d = ISSUE;
        end
        ISSUE: if (!full) begin
          push    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      din1_q  <= '0;
      din2_q  <= '0;
      sel_q   <= '0;
      qv_q    <= '0;
    end else begin
      state_q <= state_d;
      din1_q  <= din1_d;
      din2_q  <= din2_d;
      sel_q   <= sel_d;
      qv_q    <= qv_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_sel_q <= '0;
      cfg_qv_q  <= '0;
    end else if (cfg_we) begin
      cfg_sel_q <= cfg_sel;
      cfg_qv_q  <= cfg_q;
    end
  end

  mas_res_fifo #(
    .DEPTH (DEPTH),
    .T     (res_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (bus.out_ready),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (bus.out_count),
    .head_o      (head)
  );

  assign bus.out_valid = !empty;
  assign bus.out_dout  = head.dout;
  assign bus.out_tcmp  = head.tcmp;

`ifdef MAS_SEQ_STATS_EN
  logic [7:0] stat_q [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_stat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stat_q[gi] <= '0;
      end else if (clr) begin
        stat_q[gi] <= '0;
      end else if (push && (push_data.tcmp == T_W'(gi)) && (stat_q[gi] != 8'hFF)) begin
        stat_q[gi] <= stat_q[gi] + 8'd1;
      end
    end
    assign stat_cnt[gi*8 +: 8] = stat_q[gi];
  end
`endif

endmodule

// File: tb/tb_mas_operand_sequencer.sv
// Randomized and directed bench for mas_operand_sequencer against a queue-based model.
module tb_mas_operand_sequencer;
  import mas_seq_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [4:0] cfg_q;
`ifdef MAS_SEQ_STATS_EN
  logic [31:0] stat_cnt;
`endif

  mas_operand_sequencer_if #(.DEPTH(DEPTH)) bus ();

  mas_operand_sequencer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_q    (cfg_q),
`ifdef MAS_SEQ_STATS_EN
    .stat_cnt (stat_cnt),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Golden MAS: any deterministic function of the operands serves here.
  function automatic res_t mas_fn(input logic [4:0] a, input logic [4:0] b,
                                  input logic [1:0] s, input logic [4:0] q);
    logic signed [5:0] r;
    res_t o;
    case (s)
      2'd0:    r = $signed(a) + $signed(b);
      2'd1:    r = $signed(a) - $signed(b);
      2'd2:    r = $signed(a) + $signed(q);
      default: r = $signed(b) - $signed(q);
    endcase
    o.dout = r[3:0];
    o.tcmp = {$signed(a) > $signed(q), $signed(b) > $signed(q)};
    return o;
  endfunction

  assign {bus.mas_dout, bus.mas_tcmp} = mas_fn(bus.mas_din1, bus.mas_din2, bus.mas_sel, bus.mas_q);

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  logic pending, half, accepted;
  res_t pend_res;
  logic [4:0] m_din1, m_din2, m_q, m_cfg_q;
  logic [1:0] m_sel, m_cfg_sel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pending = 0; half = 0; accepted = 0;
    m_din1 = '0; m_din2 = '0; m_q = '0; m_sel = '0;
    m_cfg_q = '0; m_cfg_sel = '0;
  endtask

  // One clock: compare at the negedge, advance the model, return 1 time unit after the edge.
  task automatic cycle();
    logic exp_ready, acc, full;
    @(negedge clk);
    exp_ready = !clr && !pending;
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    check("out_count", 32'(bus.out_count), exp_q.size());
    check("mas_din1", 32'(bus.mas_din1), 32'(m_din1));
    check("mas_din2", 32'(bus.mas_din2), 32'(m_din2));
    check("mas_sel", 32'(bus.mas_sel), 32'(m_sel));
    check("mas_q", 32'(bus.mas_q), 32'(m_q));
    if (exp_q.size() != 0) begin
      check("head_dout", 32'(bus.out_dout), 32'(exp_q[0].dout));
      check("head_tcmp", 32'(bus.out_tcmp), 32'(exp_q[0].tcmp));
    end
    acc = bus.in_valid && exp_ready;
    accepted = acc;
    if (clr) begin
      exp_q.delete();
      pending = 0;
      half = 0;
    end else begin
      full = (exp_q.size() == DEPTH);
      if (bus.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (pending && !full) begin
        exp_q.push_back(pend_res);
        pending = 0;
      end
      if (acc) begin
        if (!half) begin
          m_din1 = bus.in_data;
          half = 1;
        end else begin
          m_din2 = bus.in_data;
          m_sel = m_cfg_sel;
          m_q = m_cfg_q;
          pend_res = mas_fn(m_din1, m_din2, m_sel, m_q);
          pending = 1;
          half = 0;
        end
      end
    end
    if (cfg_we) begin
      m_cfg_sel = cfg_sel;
      m_cfg_q = cfg_q;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] d);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    accepted = 0;
    for (int i = 0; i < 50 && !accepted; i++) cycle();
    check("send_accept", 32'(accepted), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_q = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);
    idle(2);

    // 1: basic pair with configured sel/q
    cfg_we = 1'b1; cfg_sel = 2'b01; cfg_q = 5'd5;
    cycle();
    cfg_we = 1'b0;
    send(5'd3);
    send(5'h1E);
    check("t1_din1", 32'(bus.mas_din1), 32'd3);
    check("t1_din2", 32'(bus.mas_din2), 32'h1E);
    check("t1_sel", 32'(bus.mas_sel), 32'd1);
    check("t1_q", 32'(bus.mas_q), 32'd5);
    check("t1_valid_pre", 32'(bus.out_valid), 32'd0);
    cycle();
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_dout", 32'(bus.out_dout), 32'd5);
    check("t1_tcmp", 32'(bus.out_tcmp), 32'd0);
    bus.out_ready = 1'b1;
    idle(2);

    // 2: fill with consumer stalled, then drain
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2*DEPTH+2; i++) send(5'($urandom));
    idle(3);
    check("t2_count", 32'(bus.out_count), 32'd4);
    check("t2_stall_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    idle(8);
    check("t2_drained", 32'(bus.out_count), 32'd0);

    // 3: pop from full while a pair waits in ISSUE, then wrap-around traffic
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2*DEPTH+2; i++) send(5'($urandom));
    idle(1);
    bus.out_ready = 1'b1;
    cycle();
    check("t3_count_pop", 32'(bus.out_count), 32'd3);
    bus.out_ready = 1'b0;
    cycle();
    check("t3_count_push", 32'(bus.out_count), 32'd4);
    for (int i = 0; i < 20; i++) begin
      bus.out_ready = 1'($urandom);
      send(5'($urandom));
    end
    bus.out_ready = 1'b1;
    idle(8);

    // 4: cfg write coinciding with the second sample
    send(5'd2);
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_q = 5'h1C;
    send(5'd6);
    cfg_we = 1'b0;
    check("t4_old_sel", 32'(bus.mas_sel), 32'd1);
    check("t4_old_q", 32'(bus.mas_q), 32'd5);
    send(5'd1);
    send(5'd1);
    check("t4_new_sel", 32'(bus.mas_sel), 32'd3);
    check("t4_new_q", 32'(bus.mas_q), 32'h1C);
    idle(3);

    // 5: clr with a half pair and queued results
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(5'($urandom));
    idle(2);
    send(5'd7);
    clr = 1'b1; bus.in_valid = 1'b1; bus.in_data = 5'd9;
    cycle();
    clr = 1'b0; bus.in_valid = 1'b0;
    check("t5_valid", 32'(bus.out_valid), 32'd0);
    check("t5_count", 32'(bus.out_count), 32'd0);
    send(5'd1);
    send(5'd1);
    check("t5_din1", 32'(bus.mas_din1), 32'd1);
    idle(2);
    bus.out_ready = 1'b1;
    idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = 1'($urandom);
      bus.in_data = 5'($urandom);
      bus.out_ready = ($urandom_range(3) != 0);
      cfg_we = ($urandom_range(7) == 0);
      cfg_sel = 2'($urandom);
      cfg_q = 5'($urandom);
      clr = ($urandom_range(49) == 0);
      cycle();
    end
    bus.in_valid = 1'b0; cfg_we = 1'b0; clr = 1'b0; bus.out_ready = 1'b0;
    idle(2);

    // 6: asynchronous reset while in ISSUE
    send(5'd4);
    send(5'h1D);
    #2 rst_n = 1'b0;
    #1;
    check("t6_in_ready", 32'(bus.in_ready), 32'd1);
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_out_count", 32'(bus.out_count), 32'd0);
    check("t6_din1", 32'(bus.mas_din1), 32'd0);
    check("t6_din2", 32'(bus.mas_din2), 32'd0);
    check("t6_sel", 32'(bus.mas_sel), 32'd0);
    check("t6_q", 32'(bus.mas_q), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(2);

`ifdef MAS_SEQ_STATS_EN
    // Tcmp = 2 for (5, -5) with q = 0; 300 pushes saturate that counter
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(5'd5);
      send(5'h1B);
    end
    idle(4);
    check("stat_cnt", stat_cnt, 32'h00FF_0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
